port_wr_enqueue: RTL and testbench

Write-side counterpart of the port read dispatcher. It receives packet beats for one output port and classifies each packet by its header priority field. It keeps a per-priority packet occupancy count and produces the queue_empty vector that the read-side WRR dispatcher consumes. The read side returns dequeue updates, and this block retires them against the counts.

---
 rtl/port_wr_enqueue_pkg.sv | 19 +
 rtl/port_wr_enqueue_if.sv | 14 +
 rtl/port_wr_enqueue_occ_counter.sv | 44 ++++
 rtl/port_wr_enqueue.sv | 137 +++++++++++++
 tb/tb_port_wr_enqueue.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/port_wr_enqueue_pkg.sv
// Shared port package: queue geometry and the write-side FSM state encoding.
// Also imported by the read-side WRR dispatcher.
package port_pkg;

  localparam int PRIOR_NUM = 8;
  localparam int PRIOR_W   = 3;
  localparam int CNT_W     = 8;
  localparam int QUEUE_CAP = 255;
  localparam int DATA_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    COMMIT,
    DROP,
    DROP_END
  } wr_state_t;

endpackage

// File: rtl/port_wr_enqueue_if.sv
// Write beat bus into port_wr_enqueue. The master drives the beats and the
// slave returns wr_rdy.
interface port_wr_enqueue_if;

  logic                        wr_vld;
  logic                        wr_sop;
  logic                        wr_eop;
  logic [port_pkg::DATA_W-1:0] wr_data;
  logic                        wr_rdy;

  modport master (output wr_vld, output wr_sop, output wr_eop, output wr_data, input  wr_rdy);
  modport slave  (input  wr_vld, input  wr_sop, input  wr_eop, input  wr_data, output wr_rdy);

endinterface

// File: rtl/port_wr_enqueue_occ_counter.sv
// Occupancy counter for one priority queue: saturating up/down count with
// registered empty/full flags derived from the next-state count.
module prior_occ_counter
  import port_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_empty,
  output logic o_full
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_empty;
  logic             r_full;

  // Simultaneous inc and dec cancel; dec at zero is ignored rather than wrapping.
  always_comb begin
    w_count_next = r_count;
    if (i_inc && !i_dec) begin
      if (r_count != CNT_W'(QUEUE_CAP)) w_count_next = r_count + 1'b1;
    end else if (i_dec && !i_inc) begin
      if (r_count != '0) w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == CNT_W'(QUEUE_CAP));
    end
  end

  assign o_empty = r_empty;
  assign o_full  = r_full;

endmodule

// File: rtl/port_wr_enqueue.sv
// Write-side packet enqueue for one output port: classifies packets by header
// priority and keeps per-queue occupancy. Optional PORT_WR_DROP_CNT_EN adds drop_cnt.
module port_wr_enqueue
  import port_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  port_wr_enqueue_if.slave     wr,
  input  logic                 deq_update,
  input  logic [PRIOR_W-1:0]   deq_prior,
  output logic [PRIOR_NUM-1:0] queue_empty,
  output logic [PRIOR_NUM-1:0] queue_full,
  output logic                 enq_done,
  output logic [PRIOR_W-1:0]   enq_prior,
  output logic                 drop_pulse
`ifdef PORT_WR_DROP_CNT_EN
  ,
  output logic [PRIOR_NUM-1:0][15:0] drop_cnt
`endif
);

  wr_state_t          r_state;
  wr_state_t          w_state_next;
  logic [PRIOR_W-1:0] r_prior;
  logic [PRIOR_W-1:0] w_prior_next;
  logic [PRIOR_W-1:0] w_hdr_prior;
  logic [PRIOR_W-1:0] w_drop_prior;
  logic [PRIOR_W-1:0] r_enq_prior;
  logic               w_accept;
  logic               w_commit;
  logic               w_drop_now;
  logic               w_rdy_next;
  logic               r_wr_rdy;
  logic               r_enq_done;
  logic               r_drop_pulse;
  logic               w_unused_data;

  assign w_accept      = wr.wr_vld && r_wr_rdy;
  assign w_hdr_prior   = wr.wr_data[PRIOR_W-1:0];
  assign w_unused_data = ^wr.wr_data[DATA_W-1:PRIOR_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_prior <= '0;
    end else begin
      r_state <= w_state_next;
      r_prior <= w_prior_next;
    end
  end

  // A header seen in RECV abandons the open packet, then is treated like a fresh header.
  always_comb begin
    w_state_next = r_state;
    w_prior_next = r_prior;
    w_commit     = 1'b0;
    w_drop_now   = 1'b0;
    w_drop_prior = r_prior;
    case (r_state)
      IDLE, RECV: begin
        if (w_accept) begin
          if (wr.wr_sop) begin
            w_drop_now   = (r_state == RECV);
            w_prior_next = w_hdr_prior;
            if (queue_full[w_hdr_prior]) w_state_next = wr.wr_eop ? DROP_END : DROP;
            else                         w_state_next = wr.wr_eop ? COMMIT : RECV;
          end else if ((r_state == RECV) && wr.wr_eop) begin
            w_state_next = COMMIT;
          end
        end
      end
      COMMIT: begin
        w_commit     = 1'b1;
        w_state_next = IDLE;
      end
      DROP: begin
        if (w_accept && wr.wr_eop) w_state_next = DROP_END;
      end
      DROP_END: begin
        w_drop_now   = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    w_rdy_next = (w_state_next == IDLE) || (w_state_next == RECV) || (w_state_next == DROP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_rdy     <= 1'b0;
      r_enq_done   <= 1'b0;
      r_enq_prior  <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_wr_rdy     <= w_rdy_next;
      r_enq_done   <= w_commit;
      r_drop_pulse <= w_drop_now;
      if (w_commit) r_enq_prior <= r_prior;
    end
  end

  for (genvar g = 0; g < PRIOR_NUM; g++) begin : g_occ
    prior_occ_counter u_occ (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_commit && (r_prior == PRIOR_W'(g))),
      .i_dec   (deq_update && (deq_prior == PRIOR_W'(g))),
      .o_empty (queue_empty[g]),
      .o_full  (queue_full[g])
    );
  end

  assign wr.wr_rdy  = r_wr_rdy;
  assign enq_done   = r_enq_done;
  assign enq_prior  = r_enq_prior;
  assign drop_pulse = r_drop_pulse;

`ifdef PORT_WR_DROP_CNT_EN
  logic [PRIOR_NUM-1:0][15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    for (int i = 0; i < PRIOR_NUM; i++) begin
      if (!rst_n) begin
        r_drop_cnt[i] <= '0;
      end else if (w_drop_now && (w_drop_prior == PRIOR_W'(i)) && (r_drop_cnt[i] != 16'hFFFF)) begin
        r_drop_cnt[i] <= r_drop_cnt[i] + 16'd1;
      end
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  logic w_unused_drop;
  assign w_unused_drop = ^w_drop_prior;
`endif

endmodule

// File: tb/tb_port_wr_enqueue.sv
// Self-checking bench for port_wr_enqueue: directed vector table, corner-case
// sequences and randomized packets against a packet-level occupancy model.
module tb_port_wr_enqueue;
  import port_pkg::*;

  logic clk;
  logic rst_n;
  logic deqUpdate;
  logic [PRIOR_W-1:0] deqPrior;
  logic [PRIOR_NUM-1:0] queueEmpty;
  logic [PRIOR_NUM-1:0] queueFull;
  logic enqDone;
  logic [PRIOR_W-1:0] enqPrior;
  logic dropPulse;
`ifdef PORT_WR_DROP_CNT_EN
  logic [PRIOR_NUM-1:0][15:0] dropCnt;
`endif

  port_wr_enqueue_if wrIf ();

  port_wr_enqueue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr          (wrIf),
    .deq_update  (deqUpdate),
    .deq_prior   (deqPrior),
    .queue_empty (queueEmpty),
    .queue_full  (queueFull),
    .enq_done    (enqDone),
    .enq_prior   (enqPrior),
    .drop_pulse  (dropPulse)
`ifdef PORT_WR_DROP_CNT_EN
    ,
    .drop_cnt    (dropCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: packet counts per queue and drops per queue.
  int mCount [PRIOR_NUM];
  int mDrop  [PRIOR_NUM];

  typedef struct {
    int         prior;
    int         beats;
    bit         deqOnCommit;
    int         deqPrior;
    logic [7:0] expEmpty;
  } vecT;

  vecT vecs [6];

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] hdr(input int p);
    logic [15:0] d;
    d = 16'($urandom);
    d[PRIOR_W-1:0] = PRIOR_W'(p);
    return d;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < PRIOR_NUM; i++) begin
      mCount[i] = 0;
      mDrop[i]  = 0;
    end
  endtask

  task automatic modelEdge(input int incP, input int dropP);
    for (int i = 0; i < PRIOR_NUM; i++) begin
      bit inc;
      bit dec;
      inc = (incP == i);
      dec = deqUpdate && (int'(deqPrior) == i);
      if (inc && !dec) mCount[i] = mCount[i] + 1;
      else if (dec && !inc && mCount[i] > 0) mCount[i] = mCount[i] - 1;
    end
    if (dropP >= 0 && mDrop[dropP] < 16'hFFFF) mDrop[dropP] = mDrop[dropP] + 1;
  endtask

  task automatic applyStimulus(input bit vld, input bit sop, input bit eop, input logic [15:0] data,
                               input bit du, input int dp);
    wrIf.wr_vld  = vld;
    wrIf.wr_sop  = sop;
    wrIf.wr_eop  = eop;
    wrIf.wr_data = data;
    deqUpdate    = du;
    deqPrior     = PRIOR_W'(dp);
  endtask

  task automatic checkOutput(input bit expRdy, input bit expDone, input int expPrior, input bit expDrop);
    logic [PRIOR_NUM-1:0] expEmpty;
    logic [PRIOR_NUM-1:0] expFull;
    for (int i = 0; i < PRIOR_NUM; i++) begin
      expEmpty[i] = (mCount[i] == 0);
      expFull[i]  = (mCount[i] == QUEUE_CAP);
    end
    checkVal("wr_rdy", int'(wrIf.wr_rdy), int'(expRdy));
    checkVal("enq_done", int'(enqDone), int'(expDone));
    if (expDone) checkVal("enq_prior", int'(enqPrior), expPrior);
    checkVal("drop_pulse", int'(dropPulse), int'(expDrop));
    checkVal("queue_empty", int'(queueEmpty), int'(expEmpty));
    checkVal("queue_full", int'(queueFull), int'(expFull));
`ifdef PORT_WR_DROP_CNT_EN
    for (int i = 0; i < PRIOR_NUM; i++) checkVal("drop_cnt", int'(dropCnt[i]), mDrop[i]);
`endif
  endtask

  task automatic tick(input bit expRdy, input bit expDone, input int expPrior, input bit expDrop,
                      input int incP, input int dropP);
    @(posedge clk);
    #1;
    if (!rst_n) modelReset();
    else        modelEdge(incP, dropP);
    checkOutput(expRdy, expDone, expPrior, expDrop);
    applyStimulus(0, 0, 0, 16'h0, 0, 0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick(0, 0, 0, 0, -1, -1);
    tick(0, 0, 0, 0, -1, -1);
    checkVal("rstEnqPrior", int'(enqPrior), 0);
    rst_n = 1'b1;
    tick(1, 0, 0, 0, -1, -1);
  endtask

  // deqCyc: -1 none, -2 random every cycle, else beat index (beats == commit cycle).
  task automatic sendPacket(input int p, input int beats, input int deqCyc, input int deqP);
    bit dropIt;
    dropIt = (mCount[p] == QUEUE_CAP);
    for (int b = 0; b <= beats; b++) begin
      bit du;
      int dp;
      if (deqCyc == -2) begin
        du = 1'($urandom_range(1));
        dp = $urandom_range(PRIOR_NUM - 1);
      end else begin
        du = (deqCyc == b);
        dp = deqP;
      end
      if (b < beats) begin
        applyStimulus(1, b == 0, b == beats - 1, (b == 0) ? hdr(p) : 16'($urandom), du, dp);
        tick(b != beats - 1, 0, 0, 0, -1, -1);
      end else begin
        applyStimulus(0, 0, 0, 16'h0, du, dp);
        tick(1, !dropIt, p, dropIt, dropIt ? -1 : p, dropIt ? p : -1);
      end
    end
  endtask

  task automatic idleTick(input bit du, input int dp);
    applyStimulus(0, 0, 0, 16'h0, du, dp);
    tick(1, 0, 0, 0, -1, -1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{5, 3, 1'b0, 0, 8'hDF};
    vecs[1] = '{0, 1, 1'b0, 0, 8'hDE};
    vecs[2] = '{2, 2, 1'b0, 0, 8'hDA};
    vecs[3] = '{2, 1, 1'b1, 2, 8'hDA};
    vecs[4] = '{7, 1, 1'b1, 6, 8'h5A};
    vecs[5] = '{0, 2, 1'b1, 5, 8'h7A};

    modelReset();
    applyStimulus(0, 0, 0, 16'h0, 0, 0);
    rst_n = 1'b0;
    doReset();
    checkVal("rstEmptyAll", int'(queueEmpty), 8'hFF);
    checkVal("rstFullNone", int'(queueFull), 0);

    for (int v = 0; v < 6; v++) begin
      sendPacket(vecs[v].prior, vecs[v].beats, vecs[v].deqOnCommit ? vecs[v].beats : -1, vecs[v].deqPrior);
      checkVal($sformatf("vecEmpty%0d", v), int'(queueEmpty), int'(vecs[v].expEmpty));
    end

    // Single-beat packet then dequeues: empty bit toggles and never underflows.
    doReset();
    sendPacket(0, 1, -1, 0);
    checkVal("q0NotEmpty", int'(queueEmpty[0]), 0);
    idleTick(1, 0);
    checkVal("q0EmptyAgain", int'(queueEmpty[0]), 1);
    idleTick(1, 0);
    idleTick(1, 6);
    checkVal("q6StillEmpty", int'(queueEmpty[6]), 1);
    sendPacket(0, 1, -1, 0);
    idleTick(1, 0);
    checkVal("q0NoUnderflow", int'(queueEmpty[0]), 1);

    // Header in RECV abandons the open packet.
    applyStimulus(1, 1, 0, hdr(1), 0, 0);
    tick(1, 0, 0, 0, -1, -1);
    applyStimulus(1, 1, 1, hdr(4), 0, 0);
    tick(0, 0, 0, 1, -1, 1);
    tick(1, 1, 4, 0, 4, -1);

    // Fill queue 3 to capacity, then exercise drops and recovery.
    doReset();
    for (int k = 0; k < QUEUE_CAP; k++) sendPacket(3, 1, -1, 0);
    checkVal("q3FullAtCap", int'(queueFull[3]), 1);
    sendPacket(3, 2, 0, 3);
    checkVal("q3AfterDrop", int'(queueFull[3]), 0);
    sendPacket(3, 1, -1, 0);
    sendPacket(3, 3, -1, 0);
    sendPacket(3, 1, -1, 0);
    checkVal("q3StillFull", int'(queueFull[3]), 1);
    idleTick(1, 3);
    sendPacket(3, 2, -1, 0);
    checkVal("q3RefilledFull", int'(queueFull[3]), 1);

    // Reset in the middle of a packet; the trailing eop beat is a stray.
    doReset();
    applyStimulus(1, 1, 0, hdr(5), 0, 0);
    tick(1, 0, 0, 0, -1, -1);
    applyStimulus(1, 0, 0, 16'h1234, 0, 0);
    tick(1, 0, 0, 0, -1, -1);
    rst_n = 1'b0;
    applyStimulus(1, 0, 1, 16'h5678, 1, 5);
    tick(0, 0, 0, 0, -1, -1);
    tick(0, 0, 0, 0, -1, -1);
    rst_n = 1'b1;
    tick(1, 0, 0, 0, -1, -1);
    applyStimulus(1, 0, 1, 16'h9ABC, 0, 0);
    tick(1, 0, 0, 0, -1, -1);
    idleTick(0, 0);
    checkVal("midRstEmpty", int'(queueEmpty), 8'hFF);

    // Randomized packets with random dequeues and stray beats.
    doReset();
    for (int n = 0; n < 250; n++) begin
      int gaps;
      sendPacket($urandom_range(PRIOR_NUM - 1), $urandom_range(1, 4), -2, 0);
      gaps = $urandom_range(2);
      for (int g = 0; g < gaps; g++) begin
        bit stray;
        stray = ($urandom_range(3) == 0);
        applyStimulus(stray, 0, stray, 16'($urandom), 1'($urandom_range(1)), $urandom_range(PRIOR_NUM - 1));
        tick(1, 0, 0, 0, -1, -1);
      end
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
